lzd_arbiter: RTL and testbench
==============================

LZD_ARBITER -- requirements
Module: lzd_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 48, mantissa width presented for normalization.
REQ-002 SHALL have parameter CNT_W, default 6, width of the leading-zero count.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each, requester holds a valid mantissa.
REQ-006 SHALL have ports req0_data / req1_data, input, DATA_W each, unnormalized mantissa.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1 each, transfer occurs when valid & ready.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port out_data, output, DATA_W, mantissa left-shifted by out_lzc (MSB = 1 unless zero).
REQ-011 SHALL have port out_lzc, output, CNT_W, leading zeros counted from bit DATA_W-1.
REQ-012 SHALL have port out_zero, output, 1, input mantissa was all zeros.
REQ-013 SHALL have port out_src, output, 1, requester index (0/1) of the result.
REQ-014 SHALL have port busy, output, 1, high when either pipeline stage holds a valid entry.

Function
REQ-015 SHALL share one leading-zero counter between two requesters via a two-stage pipeline: stage A (accept register + count), stage B (output register + shift).
REQ-016 SHALL grant combinationally: only one valid requester -> grant it; both valid -> grant the one not granted last; none -> no grant.
REQ-017 SHALL drive reqN_ready = grantN & a_load, where a_load = !A_valid | b_load, and b_load = !out_valid | out_ready.
REQ-018 SHALL update the round-robin pointer only on an accepted transfer, never on grant alone.
REQ-019 SHALL require requesters to hold valid and data stable until accepted; the block SHALL not drop or duplicate a transfer.
REQ-020 SHALL compute the count on stage-A registered data: lzc = number of zeros above the first 1; all-zero input gives lzc = 48 and out_zero = 1.
REQ-021 SHALL set out_data = A_data << lzc (zero-fill), and out_data = 0 for zero input.
REQ-022 SHALL have a latency of exactly 2 cycles from an accept edge to out_valid with out_ready held high.
REQ-023 SHALL sustain one result per cycle when out_ready = 1 continuously.
REQ-024 SHALL, while out_valid & !out_ready, hold out_data/out_lzc/out_zero/out_src stable, accept at most one further request into stage A, then deassert all readies.
REQ-025 SHALL accept a new request in the same cycle the last held result drains (simultaneous drain and accept).
REQ-026 SHALL ensure any continuously valid requester is accepted within 2 accepted transfers (no starvation).

Reset
REQ-027 SHALL, with rst_n = 0 at a clock edge, clear A_valid and out_valid, and set out_data, out_lzc, out_zero and out_src to 0.
REQ-028 SHALL, on reset, set the pointer to "last granted = 1" so that requester 0 wins the first tie.
REQ-029 SHALL discard in-flight entries on reset mid-operation, with no output after rst_n rises until a new accept.
REQ-030 SHALL hold reqN_ready low while rst_n = 0.

Structure
REQ-031 SHALL place DATA_W, CNT_W, the zero-count constant (48) and the requester-index type in a shared package.
REQ-032 SHALL instantiate exactly one combinational 48-bit leading-zero counter sub-module (the existing LZD block) in stage A; the arbiter, pointer and pipeline registers stay in lzd_arbiter.

Verification
REQ-033 SHALL cover: req0 data 0x0000_8000_0000 accepted, out_ready = 1 -> 2 cycles later out_lzc = 16, out_data = 0x8000_0000_0000, out_src = 0.
REQ-034 SHALL cover: both requesters valid every cycle after reset -> accepts alternate 0,1,0,1; 8 results in 8 consecutive cycles after 2-cycle fill.
REQ-035 SHALL cover: req1 data 0 -> out_zero = 1, out_lzc = 48, out_data = 0.
REQ-036 SHALL cover: out_ready low for 5 cycles with a steady req0 stream -> exactly one extra accept, then req0_ready = 0; outputs stable; no loss or duplication after release (scoreboard).
REQ-037 SHALL cover: rst_n pulsed low for 1 cycle with both stages full -> out_valid = 0 and busy = 0 the next cycle; the next tie is granted to req0.
REQ-038 SHALL cover: data 0x8000_0000_0000 -> out_lzc = 0, out_data unchanged.

Source files
------------

// File: rtl/lzd_arbiter_pkg.sv
// Shared constants and types for the two-requester leading-zero normalizer.
//   LZD_DATA_W   : mantissa width presented for normalization
//   LZD_CNT_W    : width of the leading-zero count
//   LZD_ZERO_CNT : count reported for an all-zero mantissa
//   req_idx_t    : requester index (0/1)
package lzd_arbiter_pkg;

    localparam int unsigned LZD_DATA_W   = 48;
    localparam int unsigned LZD_CNT_W    = 6;
    localparam int unsigned LZD_ZERO_CNT = 48;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_t;

endpackage

// File: rtl/lzd_arbiter_lzc.sv
// Combinational leading-zero counter.
//   data_i : mantissa, bit DATA_W-1 is the most significant
//   cnt_o  : number of zeros above the first 1 (LZD_ZERO_CNT when all zero)
//   zero_o : data_i is all zeros
module lzd_arbiter_lzc
    import lzd_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = LZD_DATA_W,
    parameter int unsigned CNT_W  = LZD_CNT_W
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              zero_o
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        cnt_o  = CNT_W'(LZD_ZERO_CNT);
        zero_o = 1'b1;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (data_i[i]) begin
                cnt_o  = CNT_W'(DATA_W - 1 - i);
                zero_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lzd_arbiter.sv
// Two-requester round-robin arbiter feeding one shared leading-zero
// normalizer through a two-stage pipeline.
//   Stage A: accept register, leading-zero count on the registered mantissa.
//   Stage B: output register, mantissa shifted left by the count.
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   reqN_valid/reqN_data/reqN_ready: requester handshakes (N = 0, 1)
//   out_valid/out_ready            : result handshake
//   out_data, out_lzc, out_zero    : normalized mantissa, count, zero flag
//   out_src                        : requester index of the result
//   busy                           : either pipeline stage holds an entry
module lzd_arbiter
    import lzd_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = LZD_DATA_W,
    parameter int unsigned CNT_W  = LZD_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_lzc,
    output logic              out_zero,
    output logic              out_src,
    output logic              busy
);

    // Round-robin pointer: index of the requester granted last.
    req_idx_t          ptr_q, ptr_d;

    logic              a_valid_q, a_valid_d;
    logic [DATA_W-1:0] a_data_q, a_data_d;
    req_idx_t          a_src_q, a_src_d;
    logic [CNT_W-1:0]  a_lzc;
    logic              a_zero;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_lzc_q, out_lzc_d;
    logic              out_zero_q, out_zero_d;
    req_idx_t          out_src_q, out_src_d;

    logic              grant0, grant1;
    logic              a_load, b_load;
    logic              accept;
    req_idx_t          sel_src;

    lzd_arbiter_lzc #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_lzc (
        .data_i (a_data_q),
        .cnt_o  (a_lzc),
        .zero_o (a_zero)
    );

    always_comb begin
        grant0  = req0_valid & (~req1_valid | (ptr_q == REQ1));
        grant1  = req1_valid & (~req0_valid | (ptr_q == REQ0));
        sel_src = grant1 ? REQ1 : REQ0;

        b_load  = ~out_valid_q | out_ready;
        a_load  = ~a_valid_q | b_load;

        // Readies are gated by rst_n so nothing is handed over during reset.
        req0_ready = rst_n & grant0 & a_load;
        req1_ready = rst_n & grant1 & a_load;
        accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    end

    always_comb begin
        ptr_d       = ptr_q;
        a_valid_d   = a_valid_q;
        a_data_d    = a_data_q;
        a_src_d     = a_src_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_lzc_d   = out_lzc_q;
        out_zero_d  = out_zero_q;
        out_src_d   = out_src_q;

        if (a_load) begin
            a_valid_d = accept;
            if (accept) begin
                a_data_d = grant1 ? req1_data : req0_data;
                a_src_d  = sel_src;
                // Pointer moves only on a completed transfer.
                ptr_d    = sel_src;
            end
        end

        if (b_load) begin
            out_valid_d = a_valid_q;
            if (a_valid_q) begin
                out_data_d = a_zero ? '0 : (a_data_q << a_lzc);
                out_lzc_d  = a_lzc;
                out_zero_d = a_zero;
                out_src_d  = a_src_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= REQ1;
            a_valid_q   <= 1'b0;
            a_data_q    <= '0;
            a_src_q     <= REQ0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lzc_q   <= '0;
            out_zero_q  <= 1'b0;
            out_src_q   <= REQ0;
        end else begin
            ptr_q       <= ptr_d;
            a_valid_q   <= a_valid_d;
            a_data_q    <= a_data_d;
            a_src_q     <= a_src_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lzc_q   <= out_lzc_d;
            out_zero_q  <= out_zero_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lzc   = out_lzc_q;
    assign out_zero  = out_zero_q;
    assign out_src   = out_src_q;
    assign busy      = a_valid_q | out_valid_q;

endmodule

// File: tb/tb_lzd_arbiter.sv
// Scoreboard bench for lzd_arbiter: accepted requests push the expected
// normalized result; an output monitor pops and compares each result.
module tb_lzd_arbiter;

    localparam int DW = 48;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_lzc;
    logic          out_zero, out_src, busy;

    always #5 clk = ~clk;

    lzd_arbiter #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_lzc    (out_lzc),
        .out_zero   (out_zero),
        .out_src    (out_src),
        .busy       (busy)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            lzc;
        bit            zero;
        bit            src;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;

    // stimulus controls
    int            p0, p1, n0, n1, rdy_pct;
    logic [DW-1:0] dq0[$], dq1[$];
    bit            took0, took1;
    bit            lat_chk;
    bit            m_last;

    // logs
    int            acc_src_log[$], acc_cyc_log[$], out_cyc_log[$];
    int            n_out = 0;
    logic [DW-1:0] last_data;
    int            last_lzc;
    bit            last_zero, last_src;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Normalize by shifting until the top bit is set (or 48 shifts happen).
    function automatic exp_t model(input logic [DW-1:0] d, input bit src, input int c);
        exp_t          e;
        logic [DW-1:0] v;
        int            n;
        v = d;
        n = 0;
        while (n < DW && v[DW-1] == 1'b0) begin
            v = v << 1;
            n++;
        end
        e.data = (n == DW) ? '0 : v;
        e.lzc  = n;
        e.zero = (d == '0);
        e.src  = src;
        e.cyc  = c;
        return e;
    endfunction

    function automatic logic [DW-1:0] rand_mant();
        logic [63:0] r;
        int          sh;
        r  = {$urandom(), $urandom()};
        sh = $urandom_range(DW);
        return (sh >= DW) ? '0 : (r[DW-1:0] >> sh);
    endfunction

    // Driver: holds valid/data until the transfer seen at the last negedge.
    initial begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data  = '0;   req1_data  = '0;
        out_ready  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!req0_valid || took0) begin
                req0_valid = 1'b0;
                if (n0 > 0 && $urandom_range(99) < p0) begin
                    req0_valid = 1'b1;
                    n0--;
                    req0_data = (dq0.size() > 0) ? dq0.pop_front() : rand_mant();
                end
            end
            if (!req1_valid || took1) begin
                req1_valid = 1'b0;
                if (n1 > 0 && $urandom_range(99) < p1) begin
                    req1_valid = 1'b1;
                    n1--;
                    req1_data = (dq1.size() > 0) ? dq1.pop_front() : rand_mant();
                end
            end
            out_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Accept observer: pushes expected results and checks round-robin order.
    initial begin
        m_last = 1'b1;
        forever begin
            @(negedge clk);
            took0 = 1'b0;
            took1 = 1'b0;
            if (!rst_n) begin
                exp_q.delete();
                m_last = 1'b1;
                chk("ready_in_reset", {62'd0, req1_ready, req0_ready}, 64'd0);
            end else begin
                if (req0_valid && req1_valid && (req0_ready || req1_ready))
                    chk("rr_tie_grant", {62'd0, req1_ready, req0_ready},
                        m_last ? 64'd1 : 64'd2);
                if (req0_valid && req0_ready) begin
                    exp_q.push_back(model(req0_data, 1'b0, cyc));
                    m_last = 1'b0;
                    took0  = 1'b1;
                    acc_src_log.push_back(0);
                    acc_cyc_log.push_back(cyc);
                end
                if (req1_valid && req1_ready) begin
                    exp_q.push_back(model(req1_data, 1'b1, cyc));
                    m_last = 1'b1;
                    took1  = 1'b1;
                    acc_src_log.push_back(1);
                    acc_cyc_log.push_back(cyc);
                end
            end
        end
    end

    // Output monitor: pops the scoreboard and checks stall stability.
    initial begin
        exp_t          e;
        bit            held_v;
        logic [DW-1:0] h_data;
        logic [CW-1:0] h_lzc;
        logic          h_zero, h_src;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    chk("hold_valid", {63'd0, out_valid}, 64'd1);
                    chk("hold_data", {16'd0, out_data}, {16'd0, h_data});
                    chk("hold_meta", {56'd0, out_lzc, out_zero, out_src},
                        {56'd0, h_lzc, h_zero, h_src});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", {16'd0, out_data}, {16'd0, e.data});
                        chk("out_lzc", {58'd0, out_lzc}, 64'(e.lzc));
                        chk("out_zero", {63'd0, out_zero}, {63'd0, e.zero});
                        chk("out_src", {63'd0, out_src}, {63'd0, e.src});
                        if (lat_chk)
                            chk("latency", 64'(cyc - e.cyc), 64'd2);
                    end
                    last_data = out_data;
                    last_lzc  = int'(out_lzc);
                    last_zero = out_zero;
                    last_src  = out_src;
                    out_cyc_log.push_back(cyc);
                    n_out++;
                end
                held_v = out_valid && !out_ready;
                h_data = out_data;
                h_lzc  = out_lzc;
                h_zero = out_zero;
                h_src  = out_src;
            end
        end
    end

    task automatic drain(input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            #1;
            if (n0 == 0 && n1 == 0 && !req0_valid && !req1_valid &&
                exp_q.size() == 0 && !busy)
                done = 1'b1;
        end
        chk("drain_done", {63'd0, done}, 64'd1);
    endtask

    task automatic clear_logs();
        acc_src_log.delete();
        acc_cyc_log.delete();
        out_cyc_log.delete();
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, outs0;
        p0 = 100; p1 = 0; n0 = 1; n1 = 0; rdy_pct = 100;
        lat_chk = 1'b0;
        rst_n = 1'b0;
        dq0.push_back(48'h0000_8000_0000);

        // reset values, with req0 already valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_out_data", {16'd0, out_data}, 64'd0);
        chk("rst_out_meta", {56'd0, out_lzc, out_zero, out_src}, 64'd0);
        chk("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        lat_chk = 1'b1;

        // 0x0000_8000_0000 -> lzc 16
        drain(50);
        chk("d33_lzc", 64'(last_lzc), 64'd16);
        chk("d33_data", {16'd0, last_data}, 64'h0000_8000_0000_0000);
        chk("d33_src", {63'd0, last_src}, 64'd0);

        // MSB already set -> lzc 0, data unchanged
        dq0.push_back(48'h8000_0000_0000);
        n0 = 1;
        drain(50);
        chk("d38_lzc", 64'(last_lzc), 64'd0);
        chk("d38_data", {16'd0, last_data}, 64'h0000_8000_0000_0000);

        // zero mantissa from req1
        p0 = 0;
        dq1.push_back('0);
        p1 = 100; n1 = 1;
        drain(50);
        chk("d35_zero", {63'd0, last_zero}, 64'd1);
        chk("d35_lzc", 64'(last_lzc), 64'd48);
        chk("d35_data", {16'd0, last_data}, 64'd0);
        chk("d35_src", {63'd0, last_src}, 64'd1);

        // both requesters valid every cycle after reset
        @(posedge clk);
        #1 rst_n = 1'b0;
        p0 = 100; p1 = 100; n0 = 4; n1 = 4;
        wait_neg(2);
        clear_logs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        drain(60);
        chk("d34_accepts", 64'(acc_src_log.size()), 64'd8);
        chk("d34_results", 64'(out_cyc_log.size()), 64'd8);
        if (acc_src_log.size() == 8 && out_cyc_log.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("d34_alt_src", 64'(acc_src_log[i]), 64'(i % 2));
                chk("d34_back_to_back", 64'(out_cyc_log[i] - out_cyc_log[0]), 64'(i));
            end
            chk("d34_fill", 64'(out_cyc_log[0] - acc_cyc_log[0]), 64'd2);
        end

        // output stall with a steady req0 stream
        lat_chk = 1'b0;
        p1 = 0;
        rdy_pct = 0;
        wait_neg(2);
        clear_logs();
        outs0 = n_out;
        p0 = 100; n0 = 8;
        wait_neg(7);
        chk("d36_accepts_in_stall", 64'(acc_src_log.size()), 64'd2);
        chk("d36_req0_ready_low", {62'd0, req0_valid, req0_ready}, 64'd2);
        chk("d36_out_held", {63'd0, out_valid}, 64'd1);
        rdy_pct = 100;
        drain(100);
        chk("d36_no_loss_dup", 64'(n_out - outs0), 64'd8);

        // randomized traffic with random back-pressure
        outs0 = n_out;
        p0 = 60; p1 = 60; rdy_pct = 70; n0 = 40; n1 = 40;
        drain(1500);
        chk("rand_result_count", 64'(n_out - outs0), 64'd80);

        // reset with both stages full
        rdy_pct = 0;
        p0 = 100; p1 = 100; n0 = 3; n1 = 3;
        wait_neg(5);
        chk("d37_full_before", {62'd0, busy, out_valid}, 64'd3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("d37_out_valid", {63'd0, out_valid}, 64'd0);
        chk("d37_busy", {63'd0, busy}, 64'd0);
        chk("d37_tie_to_req0", {60'd0, req1_valid, req0_valid, req1_ready, req0_ready}, 64'hD);
        rdy_pct = 100;
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
